// File: rtl/ssd_stopwatch.sv
// Two-digit BCD stopwatch with debounced run/stop and clear buttons.
// Feeds {tens, ones} to the two-digit PmodSSD display controller.
//
//   state   | meaning
//   --------+------------------------------------------------
//   STOPPED | count and prescaler frozen (reset state)
//   RUNNING | prescaler advancing, count steps on each tick
module ssd_stopwatch #(
   parameter int TICK_DIV        = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_run,
   input  logic       btn_clr,
   output logic [7:0] value,
   output logic       running,
   output logic       wrap
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {STOPPED, RUNNING} state_t;

   // Bit 0 is the run button, bit 1 the clear button.
   logic [1:0]         btn;
   logic [1:0]         sync1;
   logic [1:0]         sync2;
   logic [1:0]         deb;
   logic [1:0]         deb_d;
   logic [1:0]         press;
   logic [1:0][DW-1:0] db_cnt;

   logic               press_run;
   logic               press_clr;
   state_t             state;
   state_t             state_nxt;
   logic [PW-1:0]      presc;
   logic               tick;
   logic [7:0]         value_inc;

   assign btn       = {btn_clr, btn_run};
   assign press_run = press[0];
   assign press_clr = press[1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         deb    <= '0;
         deb_d  <= '0;
         press  <= '0;
         db_cnt <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         deb_d <= deb;
         press <= deb & ~deb_d;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Clear has priority over run/stop.
   always_comb begin
      state_nxt = state;
      if (press_clr) begin
         state_nxt = STOPPED;
      end else if (press_run) begin
         state_nxt = (state == STOPPED) ? RUNNING : STOPPED;
      end
   end

   assign tick = (state == RUNNING) && (presc == PRESC_LAST);

   always_comb begin
      value_inc = value;
      if (value[3:0] != 4'd9) begin
         value_inc[3:0] = value[3:0] + 4'd1;
      end else begin
         value_inc[3:0] = 4'd0;
         value_inc[7:4] = (value[7:4] != 4'd9) ? value[7:4] + 4'd1 : 4'd0;
      end
   end

   // A run press coincident with a tick still takes that tick because the
   // datapath looks at the current state, not the next one.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= STOPPED;
         presc   <= '0;
         value   <= 8'h00;
         running <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         state   <= state_nxt;
         running <= (state_nxt == RUNNING);
         wrap    <= 1'b0;
         if (press_clr) begin
            presc <= '0;
            value <= 8'h00;
         end else if (state == RUNNING) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
               value <= value_inc;
               wrap  <= (value == 8'h99);
            end
         end
      end
   end

endmodule

// File: tb/tb_ssd_stopwatch.sv
// Directed bench for ssd_stopwatch with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Expected values are hand-derived edge counts from the raw button edges.
module tb_ssd_stopwatch;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_run;
   logic       btn_clr;
   logic [7:0] value;
   logic       running;
   logic       wrap;

   int n_tests = 0;
   int n_fail  = 0;

   ssd_stopwatch #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_run (btn_run),
      .btn_clr (btn_clr),
      .value   (value),
      .running (running),
      .wrap    (wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit after the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raw run press; the FSM reacts on the 7th edge, where this returns.
   task automatic run_press();
      btn_run = 1'b1;
      step(7);
      btn_run = 1'b0;
   endtask

   task automatic clr_press();
      btn_clr = 1'b1;
      step(7);
      btn_clr = 1'b0;
   endtask

   initial begin
      reset   = 1'b0;
      btn_run = 1'b0;
      btn_clr = 1'b0;
      #1;

      // Reset held with buttons toggling
      for (int i = 0; i < 3; i++) begin
         btn_run = i[0];
         btn_clr = ~i[0];
         step(1);
         chk("rst_value", value, 8'h00);
         chk("rst_running", {7'd0, running}, 8'd0);
         chk("rst_wrap", {7'd0, wrap}, 8'd0);
      end
      btn_run = 1'b0;
      btn_clr = 1'b0;
      reset   = 1'b1;
      step(1);
      chk("post_rst_value", value, 8'h00);
      chk("post_rst_running", {7'd0, running}, 8'd0);
      chk("post_rst_wrap", {7'd0, wrap}, 8'd0);
      step(5);

      // Start and count: running at edge 7, value steps at edges 11, 15, 19
      btn_run = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (i == 10) btn_run = 1'b0;
         if (i == 6)  chk("start_run_e6", {7'd0, running}, 8'd0);
         if (i == 7)  chk("start_run_e7", {7'd0, running}, 8'd1);
         if (i == 10) chk("count_e10", value, 8'h00);
         if (i == 11) chk("count_e11", value, 8'h01);
         if (i == 14) chk("count_e14", value, 8'h01);
         if (i == 15) chk("count_e15", value, 8'h02);
         if (i == 19) chk("count_e19", value, 8'h03);
      end

      // Bounce: two 2-clock pulses change nothing, then a 10-clock hold stops once
      repeat (2) begin
         btn_run = 1'b1; step(2);
         btn_run = 1'b0; step(2);
      end
      step(8);
      chk("bounce_running", {7'd0, running}, 8'd1);
      btn_run = 1'b1;
      step(7);
      chk("hold_toggle", {7'd0, running}, 8'd0);
      step(3);
      btn_run = 1'b0;
      step(10);
      chk("hold_once", {7'd0, running}, 8'd0);

      clr_press();
      chk("clr_value", value, 8'h00);
      step(8);

      // Rollover from 00 over 100 ticks, entry at edge E
      run_press();
      chk("roll_entry", {7'd0, running}, 8'd1);
      for (int k = 1; k <= 401; k++) begin
         step(1);
         if (k == 36)  chk("roll_09", value, 8'h09);
         if (k == 40)  chk("roll_10", value, 8'h10);
         if (k == 76)  chk("roll_19", value, 8'h19);
         if (k == 80)  chk("roll_20", value, 8'h20);
         if (k == 396) chk("roll_99", value, 8'h99);
         if (k == 399) chk("roll_nowrap", {7'd0, wrap}, 8'd0);
         if (k == 400) chk("roll_00", value, 8'h00);
         if (k == 400) chk("roll_wrap", {7'd0, wrap}, 8'd1);
         if (k == 401) chk("roll_wrap_end", {7'd0, wrap}, 8'd0);
      end
      clr_press();
      chk("roll_clr_value", value, 8'h00);
      chk("roll_clr_running", {7'd0, running}, 8'd0);
      step(8);

      // Pause at 37 with the prescaler at 2 (stop edge = E+150), then resume
      run_press();
      step(143);
      chk("pause_pre", value, 8'h35);
      run_press();
      chk("pause_running", {7'd0, running}, 8'd0);
      chk("pause_value", value, 8'h37);
      step(50);
      chk("pause_hold", value, 8'h37);
      run_press();
      chk("resume_running", {7'd0, running}, 8'd1);
      chk("resume_r0", value, 8'h37);
      step(1);
      chk("resume_r1", value, 8'h37);
      step(1);
      chk("resume_r2", value, 8'h38);

      // Clear and run pressed together: clear wins
      step(6);
      btn_run = 1'b1;
      btn_clr = 1'b1;
      step(6);
      chk("both_e6_running", {7'd0, running}, 8'd1);
      step(1);
      btn_run = 1'b0;
      btn_clr = 1'b0;
      chk("both_value", value, 8'h00);
      chk("both_running", {7'd0, running}, 8'd0);
      chk("both_wrap", {7'd0, wrap}, 8'd0);
      step(8);
      chk("both_hold", value, 8'h00);

      // Clear coincident with the tick that would make 45 -> 46 (edge E+184)
      run_press();
      step(177);
      chk("ct_pre", value, 8'h44);
      btn_clr = 1'b1;
      step(3);
      chk("ct_45", value, 8'h45);
      step(4);
      btn_clr = 1'b0;
      chk("ct_value", value, 8'h00);
      chk("ct_running", {7'd0, running}, 8'd0);
      chk("ct_wrap", {7'd0, wrap}, 8'd0);
      step(1);
      chk("ct_after", value, 8'h00);
      step(8);

      // Reset mid-operation
      run_press();
      step(10);
      reset = 1'b0;
      step(1);
      chk("midrst_value", value, 8'h00);
      chk("midrst_running", {7'd0, running}, 8'd0);
      reset = 1'b1;
      step(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
